// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: state encoding, next-PC select, default widths, halt sentinel.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Decode compares against the same encoding to recognise end of program.
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: InstMem address/data, downstream stall/redirect, IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall from decode holds the fetch stage.
// master: fetch unit side; slave: InstMem + decode side.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted, fetch_count,
    input  imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted, fetch_count,
    output imem_data, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with hold / increment / branch next-PC select.
// Latency: new PC visible one clock after the select is applied.
// Backpressure: PC_HOLD freezes the register; increment wraps modulo 2^ADDR_W.
// Ports: clk, rst_n, pc_sel, branch_target in; pc out.
module instr_fetch_unit_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pc_sel_e           pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_HOLD:   pc_d = pc_q;
      // Natural overflow of the ADDR_W-bit add gives the 63 -> 0 wrap.
      PC_INC:    pc_d = pc_q + ADDR_W'(1);
      PC_BRANCH: pc_d = branch_target;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives InstMem address from PC, captures read data into IF/ID register.
// Latency: 1 cycle address to if_valid; 1 bubble after reset release and after redirect.
// Backpressure: stall holds PC and IF/ID; branch overrides stall; sentinel halts fetch.
// Ports: clk, rst_n, bus (master): imem_addr/imem_data, stall, branch_*, if_*, halted, fetch_count.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEF),
  parameter int unsigned       CNT_W      = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  count_q, count_d;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel        (pc_sel),
    .branch_target (bus.branch_target),
    .pc            (pc)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    halted_d = halted_q;
    count_d  = count_q;
    pc_sel   = PC_HOLD;

    unique case (state_q)
      // Single bubble after reset; inputs are deliberately ignored here.
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end

      RUN: begin
        if (bus.branch_taken) begin
          // Squash the wrong-path word; IF/ID payload and counter are left alone.
          pc_sel  = PC_BRANCH;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.imem_data;
          if_pc_d = pc;
          valid_d = 1'b1;
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
          if (bus.imem_data == HALT_INSTR) begin
            // Sentinel is delivered once; PC parks on it.
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_sel = PC_INC;
          end
        end
      end

      HALT: begin
        if (bus.branch_taken) begin
          pc_sel   = PC_BRANCH;
          state_d  = RUN;
          halted_d = 1'b0;
          valid_d  = 1'b0;
        end else if (!bus.stall) begin
          // Once decode accepts the sentinel, nothing more is presented.
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      if_pc_q  <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program sequence plus randomized stall/branch traffic.
// Latency: n/a.
// Backpressure: stall and branch driven from the bench.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;   // narrow counter so saturation is reached quickly
  localparam int          DEPTH  = 64;
  localparam int          CMAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] SENT   = 32'hFFFF_FFFF;
  localparam logic [31:0] W0     = 32'h6701_ACE6;
  localparam logic [31:0] W1     = 32'h5952_2359;
  localparam logic [31:0] W2     = 32'h1421_8670;

  logic clk;
  logic rst_n;
  logic [31:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RESET_PC   ('0),
    .HALT_INSTR (SENT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational InstMem model.
  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: fetch behaviour as plain integers.
  int          m_pc;
  int          m_mode;     // 0 boot bubble, 1 fetching, 2 parked on sentinel
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ifpc;
  bit          m_halted;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 0; m_mode = 0; m_valid = 0; m_instr = '0;
    m_ifpc = 0; m_halted = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc];
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.branch_taken) begin
        m_pc = int'(bus.branch_target);
        m_valid = 0;
      end else if (!bus.stall) begin
        m_instr = word;
        m_ifpc  = m_pc;
        m_valid = 1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (word == SENT) begin
          m_mode = 2;
          m_halted = 1;
        end else begin
          m_pc = (m_pc + 1) % DEPTH;
        end
      end
    end else begin
      if (bus.branch_taken) begin
        m_pc = int'(bus.branch_target);
        m_halted = 0;
        m_mode = 1;
        m_valid = 0;
      end else if (!bus.stall) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("imem_addr",   64'(bus.imem_addr),   64'(m_pc));
    check("if_valid",    64'(bus.if_valid),    64'(m_valid));
    check("if_instr",    64'(bus.if_instr),    64'(m_instr));
    check("if_pc",       64'(bus.if_pc),       64'(m_ifpc));
    check("halted",      64'(bus.halted),      64'(m_halted));
    check("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
  endtask

  // One clock: model advances with the inputs seen at the edge, outputs checked mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Reset pulse landing between edges; outputs must clear with no clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("async_clr_valid", 64'(bus.if_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic fill_random_mem(input int n_sent);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if (mem[i] == SENT) mem[i] = 32'h0000_0013;
    end
    for (int i = 0; i < n_sent; i++) mem[$urandom_range(DEPTH - 1, 0)] = SENT;
  endtask

  initial begin
    fill_random_mem(0);
    mem[0] = W0; mem[1] = W1; mem[2] = W2;
    mem[5] = SENT;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    rst_n = 1'b0;
    model_reset();

    // 1. reset sequencing
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle();
    check("boot_bubble", 64'(bus.if_valid), 64'd0);
    cycle();
    check("c2_instr", 64'(bus.if_instr), 64'(W0));
    check("c2_pc",    64'(bus.if_pc),    64'd0);
    cycle();
    check("c3_instr", 64'(bus.if_instr), 64'(W1));

    // 2. stall while word 1 is held
    bus.stall = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_instr", 64'(bus.if_instr),  64'(W1));
      check("stall_addr",  64'(bus.imem_addr), 64'd2);
      check("stall_cnt",   64'(bus.fetch_count), 64'd2);
    end
    bus.stall = 1'b0;
    cycle();
    check("unstall_instr", 64'(bus.if_instr), 64'(W2));
    check("cnt3",          64'(bus.fetch_count), 64'd3);

    // 3. branch beats stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd0;
    cycle();
    check("br_squash", 64'(bus.if_valid),  64'd0);
    check("br_addr",   64'(bus.imem_addr), 64'd0);
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    cycle();
    check("br_target_instr", 64'(bus.if_instr), 64'(W0));
    check("br_target_pc",    64'(bus.if_pc),    64'd0);

    // 4. halt on sentinel at word 5
    for (int i = 0; i < 20 && !m_halted; i++) cycle();
    check("halt_reached", 64'(bus.halted), 64'd1);
    check("halt_word_pc", 64'(bus.if_pc),  64'd5);
    repeat (10) begin
      cycle();
      check("halt_valid", 64'(bus.if_valid),  64'd0);
      check("halt_addr",  64'(bus.imem_addr), 64'd5);
    end
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd1;
    cycle();
    check("unhalt", 64'(bus.halted), 64'd0);
    bus.branch_taken = 1'b0;
    cycle();
    check("unhalt_instr", 64'(bus.if_instr), 64'(W1));

    // 5. PC wrap
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd63;
    cycle();
    bus.branch_taken = 1'b0;
    cycle();
    check("wrap_pc63", 64'(bus.if_pc), 64'd63);
    cycle();
    check("wrap_pc0",    64'(bus.if_pc),    64'd0);
    check("wrap_instr0", 64'(bus.if_instr), 64'(W0));

    // 6. async reset mid-stream, then boot bubble again
    check("pre_rst_valid", 64'(bus.if_valid), 64'd1);
    async_reset();
    cycle();
    check("reboot_bubble", 64'(bus.if_valid), 64'd0);
    cycle();
    check("reboot_instr", 64'(bus.if_instr), 64'(W0));

    // Randomized traffic with scattered sentinels and occasional resets.
    fill_random_mem(4);
    for (int i = 0; i < 1500; i++) begin
      bus.stall = ($urandom_range(3, 0) == 0);
      bus.branch_taken = ($urandom_range(9, 0) == 0);
      bus.branch_target = 6'($urandom_range(DEPTH - 1, 0));
      if (i % 500 == 499) begin
        async_reset();
      end else begin
        cycle();
      end
      if (i % 300 == 299) fill_random_mem(3);
    end

    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
